// File: rtl/dco_freq_lock_if.sv
// Signal bundle between the DCO frequency-lock controller and its environment.
// The master side drives the loop request, target and synchronised DCO count.
interface dco_freq_lock_if #(
    parameter int NCTRL = 64,
    parameter int CW    = 16
);
    logic             start;
    logic [CW-1:0]    target;
    logic [CW-1:0]    dco_cnt;
    logic             enable;
    logic [NCTRL-1:0] ctrl;
    logic             locked;
    logic             sat_hi;
    logic             sat_lo;
    logic [CW:0]      err;

    modport master (
        output start, target, dco_cnt,
        input  enable, ctrl, locked, sat_hi, sat_lo, err
    );

    modport slave (
        input  start, target, dco_cnt,
        output enable, ctrl, locked, sat_hi, sat_lo, err
    );
endinterface

// File: rtl/dco_freq_lock.sv
// Frequency-lock loop for the ring DCO: counts DCO edges over a refclk window,
// compares to target and steps a thermometer control word one bit per window.
module dco_freq_lock #(
    parameter int NCTRL     = 64,
    parameter int CW        = 16,
    parameter int WIN_LOG2  = 4,
    parameter int SETTLE    = 8,
    parameter int LOCK_CNT  = 4,
    parameter int TOL       = 2,
    parameter int INIT_CODE = 32
) (
    input logic            refclk,
    input logic            reset,
    dco_freq_lock_if.slave bus
);
    localparam int CODE_W = $clog2(NCTRL + 1);
    localparam int TW_A   = (WIN_LOG2 > $clog2(SETTLE)) ? WIN_LOG2 : $clog2(SETTLE);
    localparam int TW     = (TW_A < 1) ? 1 : TW_A;
    localparam int LW     = $clog2(LOCK_CNT + 1);
    localparam int EW     = CW + 1;

    localparam logic [TW-1:0]        SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0]        WIN_LAST    = TW'((1 << WIN_LOG2) - 1);
    localparam logic [CODE_W-1:0]    CODE_MAX    = CODE_W'(NCTRL);
    localparam logic [CODE_W-1:0]    CODE_INIT   = CODE_W'(INIT_CODE);
    localparam logic [LW-1:0]        LOCK_MAX    = LW'(LOCK_CNT);
    localparam logic signed [EW-1:0] TOL_P       = EW'(TOL);
    localparam logic signed [EW-1:0] TOL_N       = -EW'(TOL);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_UPDATE  = 2'd3
    } state_t;

    function automatic logic [NCTRL-1:0] therm(input logic [CODE_W-1:0] code);
        logic [NCTRL-1:0] t;
        for (int i = 0; i < NCTRL; i++) begin
            t[i] = (i < int'(code));
        end
        return t;
    endfunction

    state_t              state_r, state_nx_s;
    logic [TW-1:0]       timer_r, timer_nx_s;
    logic [CODE_W-1:0]   code_r, code_nx_s;
    logic [CW-1:0]       snap_r, snap_nx_s;
    logic [CW-1:0]       meas_r, meas_nx_s;
    logic [LW-1:0]       lockcnt_r, lockcnt_nx_s;
    logic [NCTRL-1:0]    ctrl_r;
    logic                enable_r, enable_nx_s;
    logic                locked_r, locked_nx_s;
    logic                sat_hi_r, sat_hi_nx_s;
    logic                sat_lo_r, sat_lo_nx_s;
    logic signed [EW-1:0] err_r, err_nx_s, err_calc_s;
    logic                up_s, dn_s;

    // Next-state and next-output decode for the settle/measure/update loop.
    always_comb begin
        state_nx_s   = state_r;
        timer_nx_s   = timer_r;
        code_nx_s    = code_r;
        snap_nx_s    = snap_r;
        meas_nx_s    = meas_r;
        lockcnt_nx_s = lockcnt_r;
        enable_nx_s  = enable_r;
        locked_nx_s  = locked_r;
        sat_hi_nx_s  = sat_hi_r;
        sat_lo_nx_s  = sat_lo_r;
        err_nx_s     = err_r;
        err_calc_s   = {1'b0, bus.target} - {1'b0, meas_r};
        up_s         = (err_calc_s > TOL_P);
        dn_s         = (err_calc_s < TOL_N);

        if ((state_r != S_IDLE) && !bus.start) begin
            // Stopping keeps code and err so a restart resumes where it left off.
            state_nx_s   = S_IDLE;
            timer_nx_s   = '0;
            enable_nx_s  = 1'b0;
            locked_nx_s  = 1'b0;
            lockcnt_nx_s = '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    enable_nx_s = 1'b0;
                    timer_nx_s  = '0;
                    if (bus.start) begin
                        state_nx_s  = S_SETTLE;
                        enable_nx_s = 1'b1;
                    end else begin
                        state_nx_s  = S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (timer_r == SETTLE_LAST) begin
                        snap_nx_s  = bus.dco_cnt;
                        timer_nx_s = '0;
                        state_nx_s = S_MEASURE;
                    end else begin
                        timer_nx_s = timer_r + TW'(1);
                    end
                end
                S_MEASURE: begin
                    if (timer_r == WIN_LAST) begin
                        meas_nx_s  = bus.dco_cnt - snap_r;
                        timer_nx_s = '0;
                        state_nx_s = S_UPDATE;
                    end else begin
                        timer_nx_s = timer_r + TW'(1);
                    end
                end
                S_UPDATE: begin
                    err_nx_s = err_calc_s;
                    if (up_s) begin
                        code_nx_s = (code_r == CODE_MAX) ? code_r : code_r + CODE_W'(1);
                    end else if (dn_s) begin
                        code_nx_s = (code_r == '0) ? code_r : code_r - CODE_W'(1);
                    end else begin
                        code_nx_s = code_r;
                    end
                    sat_hi_nx_s = up_s && (code_nx_s == CODE_MAX);
                    sat_lo_nx_s = dn_s && (code_nx_s == '0);
                    if (!up_s && !dn_s) begin
                        lockcnt_nx_s = (lockcnt_r == LOCK_MAX) ? lockcnt_r : lockcnt_r + LW'(1);
                        locked_nx_s  = (lockcnt_nx_s == LOCK_MAX);
                    end else begin
                        lockcnt_nx_s = '0;
                        locked_nx_s  = 1'b0;
                    end
                    timer_nx_s = '0;
                    state_nx_s = S_SETTLE;
                end
                default: begin
                    state_nx_s  = S_IDLE;
                    timer_nx_s  = '0;
                    enable_nx_s = 1'b0;
                    locked_nx_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; ctrl is always the thermometer image of the next code.
    always_ff @(posedge refclk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            timer_r   <= '0;
            code_r    <= CODE_INIT;
            snap_r    <= '0;
            meas_r    <= '0;
            lockcnt_r <= '0;
            ctrl_r    <= therm(CODE_INIT);
            enable_r  <= 1'b0;
            locked_r  <= 1'b0;
            sat_hi_r  <= 1'b0;
            sat_lo_r  <= 1'b0;
            err_r     <= '0;
        end else begin
            state_r   <= state_nx_s;
            timer_r   <= timer_nx_s;
            code_r    <= code_nx_s;
            snap_r    <= snap_nx_s;
            meas_r    <= meas_nx_s;
            lockcnt_r <= lockcnt_nx_s;
            ctrl_r    <= therm(code_nx_s);
            enable_r  <= enable_nx_s;
            locked_r  <= locked_nx_s;
            sat_hi_r  <= sat_hi_nx_s;
            sat_lo_r  <= sat_lo_nx_s;
            err_r     <= err_nx_s;
        end
    end

    assign bus.enable = enable_r;
    assign bus.ctrl   = ctrl_r;
    assign bus.locked = locked_r;
    assign bus.sat_hi = sat_hi_r;
    assign bus.sat_lo = sat_lo_r;
    assign bus.err    = err_r;
endmodule

// File: tb/tb_dco_freq_lock.sv
// Closed-loop bench: a DCO plant model counts edges from the reference model's own code,
// and each window's expected code/err/lock/saturation is computed from the loop rules.
module tb_dco_freq_lock;
    localparam int NCTRL = 64;
    localparam int CW    = 16;
    localparam int TOL   = 2;
    localparam int LOCKN = 4;
    localparam int WIN   = 16;
    localparam int ITER  = 25;

    logic refclk = 1'b0;
    logic reset;

    dco_freq_lock_if #(.NCTRL(NCTRL), .CW(CW)) bus ();

    dco_freq_lock dut (
        .refclk (refclk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 refclk = ~refclk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          m_code;
    int          m_lockcnt;
    bit          m_locked;
    bit          m_sat_hi;
    bit          m_sat_lo;
    logic [16:0] m_err;
    int          gain_fixed;

    function automatic logic [63:0] therm_of(input int c);
        logic [64:0] t;
        t = (65'd1 << c) - 65'd1;
        return t[63:0];
    endfunction

    function automatic int gain();
        return (gain_fixed != 0) ? gain_fixed : m_code / 4;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit en_exp);
        chk({tag, "/ctrl"},   bus.ctrl, therm_of(m_code));
        chk({tag, "/err"},    64'(bus.err), 64'(m_err));
        chk({tag, "/locked"}, 64'(bus.locked), 64'(m_locked));
        chk({tag, "/sat_hi"}, 64'(bus.sat_hi), 64'(m_sat_hi));
        chk({tag, "/sat_lo"}, 64'(bus.sat_lo), 64'(m_sat_lo));
        chk({tag, "/enable"}, 64'(bus.enable), 64'(en_exp));
    endtask

    task automatic model_reset();
        m_code    = 32;
        m_lockcnt = 0;
        m_locked  = 1'b0;
        m_sat_hi  = 1'b0;
        m_sat_lo  = 1'b0;
        m_err     = 17'd0;
    endtask

    // One window's worth of loop law: signed error, single step, saturation and lock tally.
    task automatic model_update();
        int meas;
        int e;
        meas = (WIN * gain()) % 65536;
        e    = int'(bus.target) - meas;
        if (e > TOL) m_code = (m_code < NCTRL) ? m_code + 1 : NCTRL;
        else if (e < -TOL) m_code = (m_code > 0) ? m_code - 1 : 0;
        m_sat_hi = (e > TOL) && (m_code == NCTRL);
        m_sat_lo = (e < -TOL) && (m_code == 0);
        if (e <= TOL && e >= -TOL) begin
            m_lockcnt = (m_lockcnt < LOCKN) ? m_lockcnt + 1 : LOCKN;
            m_locked  = (m_lockcnt == LOCKN);
        end else begin
            m_lockcnt = 0;
            m_locked  = 1'b0;
        end
        m_err = 17'(e);
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic plant();
        bus.dco_cnt = bus.dco_cnt + 16'(gain());
    endtask

    task automatic start_run(input string tag);
        bus.start = 1'b1;
        tick();
        plant();
        chk({tag, "/en_on"}, 64'(bus.enable), 64'd1);
    endtask

    // One full settle+measure+update iteration starting right after a SETTLE-entry edge.
    task automatic run_iter(input string tag, input bit preload, input int mid_tgt);
        for (int i = 1; i <= ITER; i++) begin
            tick();
            if (i == ITER) begin
                model_update();
                check_outputs(tag, 1'b1);
            end else if (i == 12) begin
                chk({tag, "/hold"}, bus.ctrl, therm_of(m_code));
            end
            if (preload && i == 7) bus.dco_cnt = 16'hFFF0;
            else plant();
            if (mid_tgt >= 0 && i == 10) bus.target = 16'(mid_tgt);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.target  = 16'd160;
        bus.dco_cnt = 16'd0;
        gain_fixed  = 0;
        model_reset();

        // Reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            plant();
            check_outputs("reset", 1'b0);
        end
        chk("reset/ctrl_lit", bus.ctrl, 64'h0000_0000_FFFF_FFFF);
        reset = 1'b0;
        start_run("t2");

        // Step up toward target 160 then lock
        for (int k = 0; k < 13; k++) run_iter("ramp", 1'b0, -1);
        chk("ramp/locked_final", 64'(bus.locked), 64'd1);
        chk("ramp/code40", bus.ctrl, 64'h0000_00FF_FFFF_FFFF);

        // Lock loss on a +10 error
        bus.target = 16'd170;
        run_iter("lockloss", 1'b0, -1);
        chk("lockloss/unlocked", 64'(bus.locked), 64'd0);
        chk("lockloss/err10", 64'(bus.err), 64'd10);
        run_iter("lockloss2", 1'b0, -1);

        // Stop in the middle of MEASURE, then resume from held code
        for (int i = 0; i < 15; i++) begin
            tick();
            plant();
        end
        bus.start = 1'b0;
        tick();
        plant();
        m_locked  = 1'b0;
        m_lockcnt = 0;
        check_outputs("stop", 1'b0);
        tick();
        plant();
        check_outputs("idle", 1'b0);
        start_run("restart");
        for (int k = 0; k < 3; k++) run_iter("resume", 1'b0, -1);

        // Random targets, some changed mid-window
        for (int k = 0; k < 10; k++) begin
            bus.target = 16'($urandom_range(100, 300));
            run_iter("rand", 1'b0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(100, 300)) : -1);
        end

        // Counter wrap inside the window
        gain_fixed = 8;
        bus.target = 16'd128;
        run_iter("wrap", 1'b1, -1);
        chk("wrap/err0", 64'(bus.err), 64'd0);
        run_iter("wrap2", 1'b1, -1);

        // Upper saturation
        gain_fixed = 0;
        bus.target = 16'hFFFF;
        for (int k = 0; k < 70; k++) run_iter("sat_hi", 1'b0, -1);
        chk("sat_hi/flag", 64'(bus.sat_hi), 64'd1);
        chk("sat_hi/ones", bus.ctrl, 64'hFFFF_FFFF_FFFF_FFFF);

        // Lower saturation
        gain_fixed = 8;
        bus.target = 16'd0;
        for (int k = 0; k < 67; k++) run_iter("sat_lo", 1'b0, -1);
        chk("sat_lo/flag", 64'(bus.sat_lo), 64'd1);
        chk("sat_lo/zero", bus.ctrl, 64'h0);

        // Reset arriving on the UPDATE edge wins
        gain_fixed = 0;
        bus.target = 16'd160;
        for (int i = 1; i < ITER; i++) begin
            tick();
            plant();
        end
        reset = 1'b1;
        tick();
        plant();
        model_reset();
        check_outputs("rst_mid", 1'b0);
        reset = 1'b0;
        start_run("post_rst");
        run_iter("post_rst", 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
